// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl: collects A, B and opcode from switches on button presses,
// drives an external combinational ALU and captures its result.
module alu_input_ctrl #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_a,
    input  logic                 i_btn_b,
    input  logic                 i_btn_op,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_alu_op_1,
    output logic [NB_DATA-1:0]   o_alu_op_2,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_result_valid,
    output logic                 o_error,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4,
        ERR     = 3'd5
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(8'h20);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(8'h22);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(8'h24);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(8'h25);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(8'h26);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(8'h03);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(8'h02);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(8'h27);

    function automatic logic is_legal(input logic [NB_OPCODE-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Button bit order: [0]=A, [1]=B, [2]=OP
    logic [2:0] btn_now;
    logic [2:0] btn_hist;
    logic [2:0] btn_pulse;

    state_t               state_q, state_next;
    logic [NB_DATA-1:0]   op_1_q, op_1_next;
    logic [NB_DATA-1:0]   op_2_q, op_2_next;
    logic [NB_OPCODE-1:0] opcode_q, opcode_next;
    logic [NB_DATA-1:0]   result_q, result_next;
    logic                 valid_q, valid_next;
    logic                 error_q, error_next;

    assign btn_now = {i_btn_op, i_btn_b, i_btn_a};

    // Edge detection: one registered pulse per press. History resets to 1 so a
    // button held through reset release must be released before it counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_hist  <= '1;
            btn_pulse <= '0;
        end else begin
            // NOTE: non-blocking so pulse uses the previous-edge history, not the value written here.
            btn_pulse <= btn_now & ~btn_hist;
            btn_hist  <= btn_now;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= WAIT_A;
            op_1_q   <= '0;
            op_2_q   <= '0;
            opcode_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_next;
            op_1_q   <= op_1_next;
            op_2_q   <= op_2_next;
            opcode_q <= opcode_next;
            result_q <= result_next;
            valid_q  <= valid_next;
            error_q  <= error_next;
        end
    end

    // Next-state and register-update logic; pulses for other buttons are ignored.
    always_comb begin
        // NOTE: every target gets a hold default first so no path infers a latch.
        state_next  = state_q;
        op_1_next   = op_1_q;
        op_2_next   = op_2_q;
        opcode_next = opcode_q;
        result_next = result_q;
        valid_next  = valid_q;
        error_next  = error_q;
        case (state_q)
            WAIT_A, SHOW, ERR: begin
                if (btn_pulse[0]) begin
                    op_1_next  = i_sw;
                    valid_next = 1'b0;
                    error_next = 1'b0;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (btn_pulse[1]) begin
                    op_2_next  = i_sw;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (btn_pulse[2]) begin
                    if (is_legal(i_sw[NB_OPCODE-1:0])) begin
                        opcode_next = i_sw[NB_OPCODE-1:0];
                        state_next  = EXEC;
                    end else begin
                        error_next = 1'b1;
                        state_next = ERR;
                    end
                end
            end
            EXEC: begin
                result_next = i_alu_result;
                valid_next  = 1'b1;
                state_next  = SHOW;
            end
            default: state_next = WAIT_A;
        endcase
    end

    assign o_alu_op_1     = op_1_q;
    assign o_alu_op_2     = op_2_q;
    assign o_alu_opcode   = opcode_q;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_error        = error_q;
    assign o_state        = state_q;

endmodule
